// File: rtl/vga_scan_timing.sv
// ============================================================================
//  Module   : vga_scan_timing
//  Purpose  : 640x480@60 raster timing with sync, blanking and a sprite window.
//             Optional VGA_BLINK_EN gates is_in_pixel with a 64-frame blink.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_scan_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int WIN_X    = 0,
    parameter int WIN_Y    = 0,
    parameter int WIN_W    = 336,
    parameter int WIN_H    = 40
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       pix_tick,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       is_in_pixel,
    output logic [9:0] win_hc,
    output logic [9:0] win_vc,
    output logic       frame_start
);

    localparam int         c_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [3:0] c_DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_VIS   = 11'(H_VIS);
    localparam logic [10:0] c_V_VIS   = 11'(V_VIS);
    localparam logic [10:0] c_HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] c_HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_BEG  = 11'(V_VIS + V_FP);
    localparam logic [10:0] c_VS_END  = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [11:0] c_WX      = 12'(WIN_X);
    localparam logic [11:0] c_WY      = 12'(WIN_Y);
    localparam logic [11:0] c_WW      = 12'(WIN_W);
    localparam logic [11:0] c_WH      = 12'(WIN_H);
    localparam logic        c_SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;
`ifdef VGA_BLINK_EN
    localparam logic        c_PIX_RST = 1'b0;
`else
    localparam logic        c_PIX_RST = (WIN_X == 0 && WIN_Y == 0 && WIN_W > 0 &&
                                         WIN_H > 0 && H_VIS > 0 && V_VIS > 0) ? 1'b1 : 1'b0;
`endif

    logic [3:0] div_q, div_d;
    logic       tick_q, tick_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_q, video_d;
    logic       pix_q, pix_d;
    logic [9:0] whc_q, whc_d;
    logic [9:0] wvc_q, wvc_d;
    logic       fs_q, fs_d;
`ifdef VGA_BLINK_EN
    logic [5:0] frm_q, frm_d;
`endif

    logic [10:0] w_hx, w_vx;
    logic [11:0] w_dx, w_dy;
    logic        w_in_win;

    always_comb begin
        div_d  = (div_q == c_DIV_LAST) ? 4'd0 : div_q + 4'd1;
        tick_d = (div_d == c_DIV_LAST);
        hc_d   = hc_q;
        vc_d   = vc_q;
        fs_d   = 1'b0;
        if (tick_q) begin
            if (hc_q == c_H_LAST) begin
                hc_d = 10'd0;
                if (vc_q == c_V_LAST) begin
                    vc_d = 10'd0;
                    fs_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // Decode from next-state counters so outputs line up with hc/vc.
        w_hx     = {1'b0, hc_d};
        w_vx     = {1'b0, vc_d};
        hsync_d  = (w_hx >= c_HS_BEG && w_hx < c_HS_END) ? c_SYNC_ON : ~c_SYNC_ON;
        vsync_d  = (w_vx >= c_VS_BEG && w_vx < c_VS_END) ? c_SYNC_ON : ~c_SYNC_ON;
        video_d  = (w_hx < c_H_VIS) && (w_vx < c_V_VIS);

        // Offsets go negative (MSB set) left of / above the window.
        w_dx     = {1'b0, w_hx} - c_WX;
        w_dy     = {1'b0, w_vx} - c_WY;
        w_in_win = video_d && !w_dx[11] && (w_dx < c_WW) && !w_dy[11] && (w_dy < c_WH);
        whc_d    = w_in_win ? w_dx[9:0] : 10'd0;
        wvc_d    = w_in_win ? w_dy[9:0] : 10'd0;
`ifdef VGA_BLINK_EN
        frm_d    = fs_d ? frm_q + 6'd1 : frm_q;
        pix_d    = w_in_win && frm_d[5];
`else
        pix_d    = w_in_win;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q   <= 4'd0;
            tick_q  <= 1'b0;
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
            hsync_q <= ~c_SYNC_ON;
            vsync_q <= ~c_SYNC_ON;
            video_q <= 1'b1;
            pix_q   <= c_PIX_RST;
            whc_q   <= 10'd0;
            wvc_q   <= 10'd0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            pix_q   <= pix_d;
            whc_q   <= whc_d;
            wvc_q   <= wvc_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VGA_BLINK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frm_q <= 6'd0;
        end else begin
            frm_q <= frm_d;
        end
    end
`endif

    assign pix_tick    = tick_q;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign is_in_pixel = pix_q;
    assign win_hc      = whc_q;
    assign win_vc      = wvc_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
// ============================================================================
//  Module   : tb_vga_scan_timing
//  Purpose  : Scoreboard bench: default-timing DUT for line/reset behaviour,
//             short-frame DUT for frame, vsync and window behaviour.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_timing;

    typedef struct packed {
        logic       tick;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pix;
        logic [9:0] whc;
        logic [9:0] wvc;
        logic       fs;
    } obs_t;

    typedef struct {
        int div, hv, hfp, hs, hbp, vv, vfp, vs, vbp, wx, wy, ww, wh;
    } cfg_t;

    logic CLK = 1'b0;
    logic rst_a, rst_b;
    always #5 CLK = ~CLK;

    logic       tick_a, hs_a, vs_a, von_a, pix_a, fs_a;
    logic [9:0] hc_a, vc_a, whc_a, wvc_a;
    logic       tick_b, hs_b, vs_b, von_b, pix_b, fs_b;
    logic [9:0] hc_b, vc_b, whc_b, wvc_b;
    obs_t       obs_a, obs_b;

    assign obs_a = {tick_a, hc_a, vc_a, hs_a, vs_a, von_a, pix_a, whc_a, wvc_a, fs_a};
    assign obs_b = {tick_b, hc_b, vc_b, hs_b, vs_b, von_b, pix_b, whc_b, wvc_b, fs_b};

    vga_scan_timing u_dut_a (
        .CLK(CLK), .RST(rst_a), .pix_tick(tick_a), .hc(hc_a), .vc(vc_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .is_in_pixel(pix_a),
        .win_hc(whc_a), .win_vc(wvc_a), .frame_start(fs_a)
    );

    vga_scan_timing #(
        .CLK_DIV(2), .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .WIN_X(100), .WIN_Y(20), .WIN_W(336), .WIN_H(8)
    ) u_dut_b (
        .CLK(CLK), .RST(rst_b), .pix_tick(tick_b), .hc(hc_b), .vc(vc_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .is_in_pixel(pix_b),
        .win_hc(whc_b), .win_vc(wvc_b), .frame_start(fs_b)
    );

    int   checks = 0;
    int   errors = 0;
    int   ta, tb;
    cfg_t ca, cb;
    obs_t q[$];

    // Expected outputs t CLK edges after reset release, from absolute tick count.
    function automatic obs_t model(input cfg_t c, input int t);
        obs_t o;
        int ht, vt, n, pos, h, v, frm;
        logic inwin;
        ht  = c.hv + c.hfp + c.hs + c.hbp;
        vt  = c.vv + c.vfp + c.vs + c.vbp;
        n   = t / c.div;
        pos = n % (ht * vt);
        frm = n / (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        o      = '0;
        o.tick = (t > 0) && (((t + 1) % c.div) == 0);
        o.hc   = 10'(h);
        o.vc   = 10'(v);
        o.hs   = !(h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hs);
        o.vs   = !(v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vs);
        o.von  = (h < c.hv) && (v < c.vv);
        inwin  = o.von && h >= c.wx && h < c.wx + c.ww && v >= c.wy && v < c.wy + c.wh;
`ifdef VGA_BLINK_EN
        o.pix  = inwin && (((frm >> 5) & 1) == 1);
`else
        o.pix  = inwin;
`endif
        o.whc  = inwin ? 10'(h - c.wx) : 10'd0;
        o.wvc  = inwin ? 10'(v - c.wy) : 10'd0;
        o.fs   = (t > 0) && ((t % c.div) == 0) && (pos == 0);
        return o;
    endfunction

    task automatic test_reset();
        obs_t e;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        e = model(ca, 0);
        checks++;
        if (obs_a !== e) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs_a, e);
        end
        checks++;
        if (hs_a !== 1'b1 || vs_a !== 1'b1 || von_a !== 1'b1 || pix_a !== 1'b1 ||
            hc_a !== 10'd0 || tick_a !== 1'b0 || fs_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_consts got hs=%b vs=%b von=%b pix=%b hc=%0d tick=%b fs=%b exp 1 1 1 1 0 0 0",
                     hs_a, vs_a, von_a, pix_a, hc_a, tick_a, fs_a);
        end
        @(negedge CLK);
        rst_a = 1'b0;
        ta    = 0;
    endtask

    task automatic test_first_tick();
        obs_t e;
        int first = -1;
        logic [9:0] hc4 = '1;
        for (int i = 0; i < 8; i++) begin
            q.push_back(model(ca, ta + 1));
            @(posedge CLK);
            #1;
            ta++;
            e = q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL first_tick_sb t=%0d got=%h exp=%h", ta, obs_a, e);
            end
            if (tick_a && first < 0) first = ta;
            if (ta == 4) hc4 = hc_a;
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL first_tick_edge got=%0d exp=3", first);
        end
        checks++;
        if (hc4 !== 10'd1) begin
            errors++;
            $display("FAIL hc_after_tick got=%0d exp=1", hc4);
        end
    endtask

    task automatic test_line();
        obs_t e;
        int hs_low = 0, voff = 0, first_hs = -1, budget = 0;
        logic wrapped = 1'b0;
        logic [9:0] phc, pvc;
        while (!(vc_a == 10'd1 && hc_a == 10'd400) && budget < 8000) begin
            phc = hc_a;
            pvc = vc_a;
            q.push_back(model(ca, ta + 1));
            @(posedge CLK);
            #1;
            ta++;
            budget++;
            e = q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL line_sb t=%0d got=%h exp=%h", ta, obs_a, e);
            end
            if (vc_a == 10'd0 && !hs_a) hs_low++;
            if (!hs_a && first_hs < 0) first_hs = int'(hc_a);
            if (vc_a == 10'd0 && !von_a) voff++;
            if (phc == 10'd799 && pvc == 10'd0 && hc_a == 10'd0 && vc_a == 10'd1) wrapped = 1'b1;
        end
        checks++;
        if (budget >= 8000) begin
            errors++;
            $display("FAIL line_timeout got hc=%0d vc=%0d exp hc=400 vc=1", hc_a, vc_a);
        end
        checks++;
        if (hs_low != 96 * 4) begin
            errors++;
            $display("FAIL hsync_width got=%0d cycles exp=%0d", hs_low, 96 * 4);
        end
        checks++;
        if (first_hs != 656) begin
            errors++;
            $display("FAIL hsync_start got hc=%0d exp=656", first_hs);
        end
        checks++;
        if (voff != 160 * 4) begin
            errors++;
            $display("FAIL hblank_width got=%0d cycles exp=%0d", voff, 160 * 4);
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL h_wrap got=0 exp=1");
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        #2;
        rst_a = 1'b1;
        #1;
        e = model(ca, 0);
        checks++;
        if (obs_a !== e) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs_a, e);
        end
        @(posedge CLK);
        @(negedge CLK);
        rst_a = 1'b0;
        ta    = 0;
        for (int i = 0; i < 12; i++) begin
            q.push_back(model(ca, ta + 1));
            @(posedge CLK);
            #1;
            ta++;
            e = q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL restart_sb t=%0d got=%h exp=%h", ta, obs_a, e);
            end
        end
        checks++;
        if (hc_a !== 10'd3 || vc_a !== 10'd0) begin
            errors++;
            $display("FAIL restart_pos got hc=%0d vc=%0d exp hc=3 vc=0", hc_a, vc_a);
        end
    endtask

    task automatic test_frame_window();
        obs_t e;
        int len = 800 * 31 * 2 + 20;
        int fs_cnt = 0, fs_t = -1, vs_low = 0, first_vs = -1, pix_cnt = 0;
        int hmin = 1023, hmax = -1, vmin = 1023, vmax = -1;
        logic seen_in = 1'b0, seen_out = 1'b0;
        logic [9:0] c_whc = '0, c_wvc = '0, o_whc = '1;
        logic c_pix = 1'b0, o_pix = 1'b1;
        @(negedge CLK);
        rst_b = 1'b0;
        tb    = 0;
        for (int i = 0; i < len; i++) begin
            q.push_back(model(cb, tb + 1));
            @(posedge CLK);
            #1;
            tb++;
            e = q.pop_front();
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL frame_sb t=%0d got=%h exp=%h", tb, obs_b, e);
            end
            if (fs_b) begin
                fs_cnt++;
                fs_t = tb;
            end
            if (!vs_b) vs_low++;
            if (!vs_b && first_vs < 0) first_vs = int'(vc_b);
            if (pix_b) begin
                pix_cnt++;
                if (int'(hc_b) < hmin) hmin = int'(hc_b);
                if (int'(hc_b) > hmax) hmax = int'(hc_b);
                if (int'(vc_b) < vmin) vmin = int'(vc_b);
                if (int'(vc_b) > vmax) vmax = int'(vc_b);
            end
            if (hc_b == 10'd435 && vc_b == 10'd23 && !seen_in) begin
                seen_in = 1'b1;
                c_pix = pix_b;
                c_whc = whc_b;
                c_wvc = wvc_b;
            end
            if (hc_b == 10'd436 && vc_b == 10'd23 && !seen_out) begin
                seen_out = 1'b1;
                o_pix = pix_b;
                o_whc = whc_b;
            end
        end
        checks++;
        if (fs_cnt != 1 || fs_t != 800 * 31 * 2) begin
            errors++;
            $display("FAIL frame_start got count=%0d t=%0d exp count=1 t=%0d", fs_cnt, fs_t, 800 * 31 * 2);
        end
        checks++;
        if (vs_low != 2 * 800 * 2 || first_vs != 26) begin
            errors++;
            $display("FAIL vsync got cycles=%0d first_vc=%0d exp cycles=3200 first_vc=26", vs_low, first_vs);
        end
        checks++;
        if (!seen_in || c_whc !== 10'd335 || c_wvc !== 10'd3) begin
            errors++;
            $display("FAIL win_corner got seen=%b whc=%0d wvc=%0d exp seen=1 whc=335 wvc=3", seen_in, c_whc, c_wvc);
        end
        checks++;
        if (!seen_out || o_pix !== 1'b0 || o_whc !== 10'd0) begin
            errors++;
            $display("FAIL win_outside got seen=%b pix=%b whc=%0d exp seen=1 pix=0 whc=0", seen_out, o_pix, o_whc);
        end
`ifdef VGA_BLINK_EN
        checks++;
        if (pix_cnt != 0 || c_pix !== 1'b0) begin
            errors++;
            $display("FAIL blink_off got cycles=%0d corner_pix=%b exp 0 0", pix_cnt, c_pix);
        end
`else
        checks++;
        if (c_pix !== 1'b1) begin
            errors++;
            $display("FAIL win_corner_pix got=%b exp=1", c_pix);
        end
        checks++;
        if (pix_cnt != 336 * 4 * 2 || hmin != 100 || hmax != 435 || vmin != 20 || vmax != 23) begin
            errors++;
            $display("FAIL win_extent got cycles=%0d h=%0d..%0d v=%0d..%0d exp cycles=2688 h=100..435 v=20..23",
                     pix_cnt, hmin, hmax, vmin, vmax);
        end
`endif
    endtask

    initial begin
        ca = '{div: 4, hv: 640, hfp: 16, hs: 96, hbp: 48, vv: 480, vfp: 10, vs: 2, vbp: 33,
               wx: 0, wy: 0, ww: 336, wh: 40};
        cb = '{div: 2, hv: 640, hfp: 16, hs: 96, hbp: 48, vv: 24, vfp: 2, vs: 2, vbp: 3,
               wx: 100, wy: 20, ww: 336, wh: 8};
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_first_tick();
        test_line();
        test_async_reset();
        test_frame_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
